// File: rtl/gbc_vram_dma_if.sv
// Memory-side port bundle of the GBC VRAM DMA engine.
// Separate read and write request/ack channels to the arbiter.
interface gbc_vram_dma_if;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_req;
  logic [15:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_ack;

  modport master (
    output mem_rd_req, mem_rd_addr,
    input  mem_rd_ack, mem_rd_data,
    output mem_wr_req, mem_wr_addr, mem_wr_data,
    input  mem_wr_ack
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr,
    output mem_rd_ack, mem_rd_data,
    input  mem_wr_req, mem_wr_addr, mem_wr_data,
    output mem_wr_ack
  );
endinterface

// File: rtl/gbc_vram_dma.sv
// GBC VRAM DMA engine (FF51-FF55), GDMA and HDMA modes.
// Bytes move through a req/ack read phase, then a req/ack write phase.
module gbc_vram_dma #(
  parameter int          BLOCK_BYTES   = 16,
  parameter int          LEN_BITS      = 7,
  parameter logic [15:0] TGT_BASE      = 16'h8000,
  parameter int          TGT_SPAN_BITS = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_reg,
  input  logic [3:0]  addr,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [1:0]  lcd_mode,
  input  logic        lcd_on,
  output logic        cpu_halt,
  output logic        busy,
  output logic        done,
  gbc_vram_dma_if.master mem
);
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam int BW = LEN_BITS + 1;
  localparam int TW = TGT_SPAN_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HB, S_RD, S_WR, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            rd_req_q, rd_req_d;
  logic            wr_req_q, wr_req_d;
  logic [15:0]     src_ptr_q;
  logic [TW-1:0]   tgt_off_q;
  logic [BW-1:0]   blk_left_q;
  logic [CW-1:0]   byte_cnt_q;
  logic            hdma_q;
  logic            hb_armed_q;
  logic            cancel_q;
  logic [7:0]      data_q;

  logic w51, w52, w53, w54, w55;
  logic cfg_ok, xfer_on;
  logic rd_fire, wr_fire, last_byte, hb_go;
  logic hdma_cancel, hdma_reload, cancel_now;
  logic [BW-1:0] blk_new;

  assign w51 = sel_reg && wr && addr == 4'd1;
  assign w52 = sel_reg && wr && addr == 4'd2;
  assign w53 = sel_reg && wr && addr == 4'd3;
  assign w54 = sel_reg && wr && addr == 4'd4;
  assign w55 = sel_reg && wr && addr == 4'd5;

  assign cfg_ok  = state_q == S_IDLE || state_q == S_WAIT_HB;
  assign xfer_on = state_q == S_WAIT_HB || state_q == S_RD ||
                   state_q == S_WR;

  assign rd_fire   = rd_req_q && mem.mem_rd_ack;
  assign wr_fire   = wr_req_q && mem.mem_wr_ack;
  assign last_byte = byte_cnt_q == CW'(BLOCK_BYTES - 1);
  assign hb_go     = (hb_armed_q && lcd_mode == 2'd0) || !lcd_on;

  assign hdma_cancel = w55 && !din[7] && hdma_q && xfer_on;
  assign hdma_reload = w55 && din[7] && hdma_q && xfer_on;
  assign cancel_now  = cancel_q || hdma_cancel;
  assign blk_new     = BW'(din[LEN_BITS-1:0]) + BW'(1);

  assign mem.mem_rd_req  = rd_req_q;
  assign mem.mem_rd_addr = src_ptr_q;
  assign mem.mem_wr_req  = wr_req_q;
  assign mem.mem_wr_addr = TGT_BASE | 16'(tgt_off_q);
  assign mem.mem_wr_data = data_q;

  // state and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
    end
  end

  // next state; requests rise one cycle after entry, drop after ack
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (w55) state_d = din[7] ? S_WAIT_HB : S_RD;
      S_WAIT_HB:
        if (hdma_cancel) state_d = S_IDLE;
        else if (hb_go)  state_d = S_RD;
      S_RD:
        if (rd_fire) state_d = S_WR;
      S_WR:
        if (wr_fire) begin
          if (cancel_now)
            state_d = S_IDLE;
          else if (last_byte && blk_left_q == BW'(1))
            state_d = S_DONE;
          else if (last_byte && hdma_q)
            state_d = S_WAIT_HB;
          else
            state_d = S_RD;
        end
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    rd_req_d = state_q == S_RD && !rd_fire;
    wr_req_d = state_q == S_WR && !wr_fire;
  end

  // status outputs and register read-back
  always_comb begin
    cpu_halt = state_q == S_RD || state_q == S_WR;
    busy     = state_q != S_IDLE;
    done     = state_q == S_DONE;
    dout     = 8'hFF;
    if (sel_reg && addr == 4'd5)
      dout = {state_q == S_IDLE, 7'(blk_left_q - BW'(1))};
  end

  // pointers, counters, mode flags and data latch
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr_q  <= 16'hFFF0;
      tgt_off_q  <= {{(TW-4){1'b1}}, 4'h0};
      blk_left_q <= '0;
      byte_cnt_q <= '0;
      hdma_q     <= 1'b0;
      hb_armed_q <= 1'b0;
      cancel_q   <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      if (cfg_ok && w51) begin
        src_ptr_q[15:8] <= din;
        src_ptr_q[3:0]  <= 4'h0;
      end
      if (cfg_ok && w52) begin
        src_ptr_q[7:4] <= din[7:4];
        src_ptr_q[3:0] <= 4'h0;
      end
      if (cfg_ok && w53) begin
        tgt_off_q[TW-1:8] <= din[TW-9:0];
        tgt_off_q[3:0]    <= 4'h0;
      end
      if (cfg_ok && w54) begin
        tgt_off_q[7:4] <= din[7:4];
        tgt_off_q[3:0] <= 4'h0;
      end
      if (state_q == S_IDLE && w55) begin
        blk_left_q <= blk_new;
        byte_cnt_q <= '0;
        hdma_q     <= din[7];
        cancel_q   <= 1'b0;
      end else if (hdma_reload) begin
        blk_left_q <= blk_new;
      end
      if (hdma_cancel && state_q != S_WAIT_HB)
        cancel_q <= 1'b1;
      if (rd_fire)
        data_q <= mem.mem_rd_data;
      if (wr_fire) begin
        src_ptr_q  <= src_ptr_q + 16'd1;
        tgt_off_q  <= tgt_off_q + TW'(1);
        byte_cnt_q <= byte_cnt_q + CW'(1);
        if (last_byte && !hdma_reload)
          blk_left_q <= blk_left_q - BW'(1);
      end
      if (state_q == S_IDLE && w55)
        hb_armed_q <= din[7];
      else if (state_q == S_WAIT_HB && hb_go && !hdma_cancel)
        hb_armed_q <= 1'b0;
      else if (lcd_mode != 2'd0)
        hb_armed_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gbc_vram_dma.sv
// Bench for gbc_vram_dma: memory responder with programmable
// latency, scoreboard of expected rd/wr pairs, scenario tasks.
module tb_gbc_vram_dma;
  logic       clk = 1'b0;
  logic       reset;
  logic       sel_reg;
  logic [3:0] addr;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic [1:0] lcd_mode;
  logic       lcd_on;
  logic       cpu_halt;
  logic       busy;
  logic       done;

  gbc_vram_dma_if mif ();

  gbc_vram_dma dut (
    .clk      (clk),
    .reset    (reset),
    .sel_reg  (sel_reg),
    .addr     (addr),
    .wr       (wr),
    .din      (din),
    .dout     (dout),
    .lcd_mode (lcd_mode),
    .lcd_on   (lcd_on),
    .cpu_halt (cpu_halt),
    .busy     (busy),
    .done     (done),
    .mem      (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ra;
    logic [15:0] wa;
    logic [7:0]  d;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt, wr_cnt, done_cnt;
  int rd_delay = 0;
  int wr_delay = 0;
  int rc, wc, rd_hold, wr_hold;
  logic rd_prev, wr_prev;
  logic [15:0] rd_prev_a, wr_prev_a;
  logic [7:0] wr_prev_d;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // memory responder: ack after rd_delay/wr_delay extra req cycles
  initial begin
    rc = 0;
    wc = 0;
    mif.mem_rd_ack  = 1'b0;
    mif.mem_wr_ack  = 1'b0;
    mif.mem_rd_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mif.mem_rd_ack) mif.mem_rd_ack = 1'b0;
      else if (mif.mem_rd_req) begin
        if (rc >= rd_delay) begin
          mif.mem_rd_ack  = 1'b1;
          mif.mem_rd_data = mem_byte(mif.mem_rd_addr);
          rc = 0;
        end else rc++;
      end else rc = 0;
      if (mif.mem_wr_ack) mif.mem_wr_ack = 1'b0;
      else if (mif.mem_wr_req) begin
        if (wc >= wr_delay) begin
          mif.mem_wr_ack = 1'b1;
          wc = 0;
        end else wc++;
      end else wc = 0;
    end
  end

  // scoreboard consumer and handshake monitor
  initial begin
    rd_hold = 0;
    wr_hold = 0;
    rd_prev = 1'b0;
    wr_prev = 1'b0;
    rd_prev_a = '0;
    wr_prev_a = '0;
    wr_prev_d = '0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mif.mem_rd_req) begin
        if (rd_prev) begin
          n_chk++;
          if (mif.mem_rd_addr !== rd_prev_a) begin
            n_fail++;
            $display("FAIL rd_stable addr=%h was %h",
                     mif.mem_rd_addr, rd_prev_a);
          end
        end
        n_chk++;
        if (cpu_halt !== 1'b1) begin
          n_fail++;
          $display("FAIL halt_rd got %b want 1", cpu_halt);
        end
        rd_hold++;
        if (mif.mem_rd_ack) begin
          rd_cnt++;
          n_chk++;
          if (rd_hold != rd_delay + 1) begin
            n_fail++;
            $display("FAIL rd_hold got %0d want %0d",
                     rd_hold, rd_delay + 1);
          end
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected addr=%h want none",
                     mif.mem_rd_addr);
          end else if (mif.mem_rd_addr !== exp_q[0].ra) begin
            n_fail++;
            $display("FAIL rd_addr got %h want %h",
                     mif.mem_rd_addr, exp_q[0].ra);
          end
          rd_hold = 0;
        end
      end else rd_hold = 0;
      if (mif.mem_wr_req) begin
        if (wr_prev) begin
          n_chk++;
          if (mif.mem_wr_addr !== wr_prev_a ||
              mif.mem_wr_data !== wr_prev_d) begin
            n_fail++;
            $display("FAIL wr_stable a/d=%h/%h was %h/%h",
                     mif.mem_wr_addr, mif.mem_wr_data,
                     wr_prev_a, wr_prev_d);
          end
        end
        n_chk++;
        if (cpu_halt !== 1'b1) begin
          n_fail++;
          $display("FAIL halt_wr got %b want 1", cpu_halt);
        end
        wr_hold++;
        if (mif.mem_wr_ack) begin
          exp_t e;
          wr_cnt++;
          n_chk++;
          if (wr_hold != wr_delay + 1) begin
            n_fail++;
            $display("FAIL wr_hold got %0d want %0d",
                     wr_hold, wr_delay + 1);
          end
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_unexpected addr=%h want none",
                     mif.mem_wr_addr);
          end else begin
            e = exp_q.pop_front();
            if (mif.mem_wr_addr !== e.wa ||
                mif.mem_wr_data !== e.d) begin
              n_fail++;
              $display("FAIL wr_pair got %h/%h want %h/%h",
                       mif.mem_wr_addr, mif.mem_wr_data,
                       e.wa, e.d);
            end
          end
          wr_hold = 0;
        end
      end else wr_hold = 0;
      if (done) done_cnt++;
    end
    rd_prev   = mif.mem_rd_req && !mif.mem_rd_ack && !reset;
    rd_prev_a = mif.mem_rd_addr;
    wr_prev   = mif.mem_wr_req && !mif.mem_wr_ack && !reset;
    wr_prev_a = mif.mem_wr_addr;
    wr_prev_d = mif.mem_wr_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] a,
                           input logic [7:0] d);
    sel_reg = 1'b1;
    wr      = 1'b1;
    addr    = a;
    din     = d;
    tick(1);
    sel_reg = 1'b0;
    wr      = 1'b0;
    addr    = 4'd0;
    din     = 8'h00;
  endtask

  task automatic read_reg(input logic [3:0] a,
                          output logic [7:0] v);
    sel_reg = 1'b1;
    addr    = a;
    #1;
    v       = dout;
    sel_reg = 1'b0;
    addr    = 4'd0;
  endtask

  task automatic set_ptrs(input logic [15:0] s,
                          input logic [12:0] t);
    reg_write(4'd1, s[15:8]);
    reg_write(4'd2, s[7:0]);
    reg_write(4'd3, {3'b000, t[12:8]});
    reg_write(4'd4, t[7:0]);
  endtask

  task automatic push_exp(input logic [15:0] s,
                          input logic [12:0] t, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.ra = s + 16'(i);
      e.wa = 16'h8000 | ((16'(t) + 16'(i)) & 16'h1FFF);
      e.d  = mem_byte(e.ra);
      exp_q.push_back(e);
    end
  endtask

  task automatic clr_counts();
    rd_cnt   = 0;
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick(1);
      i++;
    end
    n_chk++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_timeout busy=%b want 0", nm, busy);
    end
  endtask

  task automatic wait_wr_req(input string nm, input int budget);
    int i;
    i = 0;
    while (!mif.mem_wr_req && i < budget) begin
      tick(1);
      i++;
    end
    n_chk++;
    if (!mif.mem_wr_req) begin
      n_fail++;
      $display("FAIL %s_wrreq got 0 want 1", nm);
    end
  endtask

  task automatic check_end(input string nm, input int n,
                           input int nd, input logic [7:0] f55);
    logic [7:0] v;
    n_chk++;
    if (rd_cnt != n || wr_cnt != n) begin
      n_fail++;
      $display("FAIL %s_count rd=%0d wr=%0d want %0d",
               nm, rd_cnt, wr_cnt, n);
    end
    n_chk++;
    if (done_cnt != nd) begin
      n_fail++;
      $display("FAIL %s_done got %0d want %0d", nm, done_cnt, nd);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover got %0d want 0",
               nm, exp_q.size());
    end
    read_reg(4'd5, v);
    n_chk++;
    if (v !== f55) begin
      n_fail++;
      $display("FAIL %s_ff55 got %h want %h", nm, v, f55);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    n_chk++;
    if ({mif.mem_rd_req, mif.mem_wr_req, cpu_halt, busy, done}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs got %b want 00000",
               {mif.mem_rd_req, mif.mem_wr_req, cpu_halt, busy, done});
    end
    read_reg(4'd5, v);
    n_chk++;
    if (v !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_ff55 got %h want ff", v);
    end
    read_reg(4'd1, v);
    n_chk++;
    if (v !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_ff51 got %h want ff", v);
    end
    addr = 4'd5;
    #1;
    n_chk++;
    if (dout !== 8'hFF) begin
      n_fail++;
      $display("FAIL nosel_read got %h want ff", dout);
    end
    addr = 4'd0;
  endtask

  task automatic test_gdma();
    clr_counts();
    set_ptrs(16'h2040, 13'h0200);
    push_exp(16'h2040, 13'h0200, 32);
    reg_write(4'd5, 8'h01);
    wait_idle("gdma", 400);
    check_end("gdma", 32, 1, 8'hFF);
  endtask

  task automatic test_hdma();
    logic [7:0] v;
    logic [7:0] want;
    clr_counts();
    lcd_on   = 1'b1;
    lcd_mode = 2'd2;
    set_ptrs(16'h1230, 13'h0400);
    push_exp(16'h1230, 13'h0400, 48);
    reg_write(4'd5, 8'h82);
    for (int k = 0; k < 3; k++) begin
      lcd_mode = 2'd2;
      tick(10);
      n_chk++;
      if (wr_cnt != 16 * k) begin
        n_fail++;
        $display("FAIL hdma_hold%0d got %0d want %0d",
                 k, wr_cnt, 16 * k);
      end
      lcd_mode = 2'd3;
      tick(5);
      lcd_mode = 2'd0;
      tick(150);
      n_chk++;
      if (wr_cnt != 16 * (k + 1)) begin
        n_fail++;
        $display("FAIL hdma_blk%0d got %0d want %0d",
                 k, wr_cnt, 16 * (k + 1));
      end
      want = (k == 0) ? 8'h01 : (k == 1) ? 8'h00 : 8'hFF;
      read_reg(4'd5, v);
      n_chk++;
      if (v !== want) begin
        n_fail++;
        $display("FAIL hdma_ff55_%0d got %h want %h", k, v, want);
      end
    end
    check_end("hdma", 48, 1, 8'hFF);
    lcd_mode = 2'd2;
  endtask

  task automatic test_cancel();
    clr_counts();
    lcd_on   = 1'b1;
    lcd_mode = 2'd2;
    wr_delay = 4;
    set_ptrs(16'h3000, 13'h0000);
    push_exp(16'h3000, 13'h0000, 1);
    reg_write(4'd5, 8'h81);
    lcd_mode = 2'd0;
    wait_wr_req("cancel", 100);
    reg_write(4'd5, 8'h00);
    wait_idle("cancel", 100);
    lcd_mode = 2'd2;
    tick(5);
    check_end("cancel", 1, 0, 8'h81);
    wr_delay = 0;
  endtask

  task automatic test_lcd_off();
    clr_counts();
    lcd_on   = 1'b0;
    lcd_mode = 2'd3;
    set_ptrs(16'h4000, 13'h0100);
    push_exp(16'h4000, 13'h0100, 32);
    reg_write(4'd5, 8'h81);
    wait_idle("lcdoff", 400);
    check_end("lcdoff", 32, 1, 8'hFF);
    lcd_on = 1'b1;
  endtask

  task automatic test_wrap();
    clr_counts();
    set_ptrs(16'hFFF0, 13'h1FF0);
    push_exp(16'hFFF0, 13'h1FF0, 32);
    reg_write(4'd5, 8'h01);
    wait_idle("wrap", 400);
    check_end("wrap", 32, 1, 8'hFF);
  endtask

  task automatic test_delay_reset();
    logic [7:0] v;
    clr_counts();
    rd_delay = 5;
    wr_delay = 20;
    set_ptrs(16'h5000, 13'h0000);
    push_exp(16'h5000, 13'h0000, 16);
    reg_write(4'd5, 8'h00);
    wait_wr_req("dlyrst", 100);
    tick(2);
    n_chk++;
    if (rd_cnt != 1 || wr_cnt != 0) begin
      n_fail++;
      $display("FAIL dlyrst_progress rd=%0d wr=%0d want 1/0",
               rd_cnt, wr_cnt);
    end
    reset = 1'b1;
    tick(1);
    n_chk++;
    if ({mif.mem_rd_req, mif.mem_wr_req, cpu_halt, busy, done}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL dlyrst_outs got %b want 00000",
               {mif.mem_rd_req, mif.mem_wr_req, cpu_halt, busy, done});
    end
    read_reg(4'd5, v);
    n_chk++;
    if (v !== 8'hFF) begin
      n_fail++;
      $display("FAIL dlyrst_ff55 got %h want ff", v);
    end
    reset = 1'b0;
    exp_q.delete();
    rd_delay = 0;
    wr_delay = 0;
    tick(3);
    n_chk++;
    if (busy || mif.mem_rd_req || mif.mem_wr_req) begin
      n_fail++;
      $display("FAIL dlyrst_quiet got %b%b%b want 000",
               busy, mif.mem_rd_req, mif.mem_wr_req);
    end
  endtask

  initial begin
    reset    = 1'b1;
    sel_reg  = 1'b0;
    addr     = 4'd0;
    wr       = 1'b0;
    din      = 8'h00;
    lcd_mode = 2'd2;
    lcd_on   = 1'b1;
    clr_counts();
    test_reset();
    test_gdma();
    test_hdma();
    test_cancel();
    test_lcd_off();
    test_wrap();
    test_delay_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
